// File: rtl/npc_predict_pkg.sv
// Shared encodings for the next-PC predictor: resolution kinds, counter states,
// and small helpers used by the BTB write port.
package npc_predict_pkg;

  typedef enum logic [1:0] {
    UPD_BRANCH = 2'd0,
    UPD_JAL    = 2'd1,
    UPD_JALR   = 2'd2,
    UPD_RSVD   = 2'd3
  } upd_kind_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Reserved kind 3 falls through as a plain conditional branch.
  function automatic logic isJumpKind(input logic [1:0] kind);
    return (kind == UPD_JAL) || (kind == UPD_JALR);
  endfunction

  function automatic logic [1:0] ctrStep(input logic [1:0] ctr, input logic taken);
    logic [1:0] nextCtr;
    nextCtr = ctr;
    if (taken && (ctr != CTR_ST)) begin
      nextCtr = ctr + 2'd1;
    end else if (!taken && (ctr != CTR_SNT)) begin
      nextCtr = ctr - 2'd1;
    end
    return nextCtr;
  endfunction

endpackage

// File: rtl/npc_predict_btb_bank.sv
// Direct-mapped branch target buffer: combinational lookup port and a single
// write port that trains the 2-bit direction counters.
module btb_bank
  import npc_predict_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  localparam int IDX_W      = $clog2(BTB_ENTRIES),
  localparam int TAG_W      = XLEN - IDX_W - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_taken_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            wr_en_i,
  input  logic [1:0]      wr_kind_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic            wr_taken_i,
  input  logic [XLEN-1:0] wr_target_i
);

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [BTB_ENTRIES-1:0] isJump_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0] rdIdx;
  logic [TAG_W-1:0] rdTag;
  logic             rdHit;

  logic [IDX_W-1:0] wrIdx;
  logic [TAG_W-1:0] wrTag;
  logic             wrHit;
  logic             wrJump;
  logic             wrWe;
  logic [XLEN-1:0]  target_d;
  logic [1:0]       ctr_d;
  logic             isJump_d;

  logic unusedPcBits;
  assign unusedPcBits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  assign rdIdx       = rd_pc_i[IDX_W+1:2];
  assign rdTag       = rd_pc_i[XLEN-1:IDX_W+2];
  assign rdHit       = valid_q[rdIdx] && (tag_q[rdIdx] == rdTag);
  assign rd_taken_o  = rdHit && (isJump_q[rdIdx] || ctr_q[rdIdx][1]);
  assign rd_target_o = target_q[rdIdx];

  assign wrIdx  = wr_pc_i[IDX_W+1:2];
  assign wrTag  = wr_pc_i[XLEN-1:IDX_W+2];
  assign wrHit  = valid_q[wrIdx] && (tag_q[wrIdx] == wrTag);
  assign wrJump = isJumpKind(wr_kind_i);

  // A not-taken miss leaves the entry alone so cold branches never allocate.
  always_comb begin
    wrWe     = 1'b0;
    target_d = target_q[wrIdx];
    ctr_d    = ctr_q[wrIdx];
    isJump_d = isJump_q[wrIdx];
    if (wr_en_i) begin
      if (wrHit) begin
        wrWe = 1'b1;
        if (wrJump) begin
          ctr_d    = CTR_ST;
          isJump_d = 1'b1;
          target_d = wr_target_i;
        end else begin
          ctr_d = ctrStep(ctr_q[wrIdx], wr_taken_i);
          if (wr_taken_i) begin
            target_d = wr_target_i;
          end
        end
      end else if (wr_taken_i) begin
        wrWe     = 1'b1;
        target_d = wr_target_i;
        ctr_d    = wrJump ? CTR_ST : CTR_WT;
        isJump_d = wrJump;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      isJump_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (wrWe) begin
      valid_q[wrIdx]  <= 1'b1;
      isJump_q[wrIdx] <= isJump_d;
      tag_q[wrIdx]    <= wrTag;
      target_q[wrIdx] <= target_d;
      ctr_q[wrIdx]    <= ctr_d;
    end
  end

endmodule

// File: rtl/npc_predict.sv
// Fetch PC register with BTB-driven prediction and mispredict redirect from
// downstream resolution.
module npc_predict
  import npc_predict_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [1:0]      upd_kind_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pcPlus4;
  logic            btbTaken;
  logic [XLEN-1:0] btbTarget;

  btb_bank #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .rd_pc_i     (pc_q),
    .rd_taken_o  (btbTaken),
    .rd_target_o (btbTarget),
    .wr_en_i     (upd_valid_i),
    .wr_kind_i   (upd_kind_i),
    .wr_pc_i     (upd_pc_i),
    .wr_taken_i  (upd_taken_i),
    .wr_target_i (upd_target_i)
  );

  assign pc_o          = pc_q;
  assign pcPlus4       = pc_q + XLEN'(4);
  assign pred_taken_o  = btbTaken;
  assign pred_target_o = btbTaken ? btbTarget : pcPlus4;

  // The target only matters when the instruction was actually taken.
  assign redirect_o = upd_valid_i &&
                      ((upd_taken_i != upd_pred_taken_i) ||
                       (upd_taken_i && (upd_target_i != upd_pred_target_i)));
  assign redirect_pc_o = !redirect_o ? '0 :
                         (upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4));

  always_comb begin
    pc_d = pcPlus4;
    if (redirect_o) begin
      pc_d = redirect_pc_o;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (pred_taken_o) begin
      pc_d = pred_target_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_npc_predict.sv
// Scoreboard bench for npc_predict: directed scenarios followed by random
// resolutions, checked against an array-based model of the predictor rules.
module tb_npc_predict;
  import npc_predict_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i = 1'b0;
  logic [1:0]  upd_kind_i = 2'd0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_pred_taken_i = 1'b0;
  logic [31:0] upd_pred_target_i = '0;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  npc_predict #(.XLEN(32), .BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .pc_o              (pc_o),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .upd_valid_i       (upd_valid_i),
    .upd_kind_i        (upd_kind_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .redirect_o        (redirect_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [31:0] tag;
    bit [31:0] target;
    int        ctr;
    bit        isJump;
  } entry_t;

  typedef struct {
    logic [31:0] pc;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        redirect;
    logic [31:0] redirectPc;
  } exp_t;

  entry_t    model [N];
  bit [31:0] modelPc;
  exp_t      expQ [$];
  int        checks = 0;
  int        failures = 0;

  function automatic void modelReset();
    modelPc = 32'h0;
    foreach (model[i]) model[i] = '{v: 1'b0, tag: 32'h0, target: 32'h0, ctr: 1, isJump: 1'b0};
  endfunction

  function automatic int idxOf(bit [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic bit modelTaken(bit [31:0] pc);
    entry_t e;
    e = model[idxOf(pc)];
    return e.v && (e.tag == pc / (4 * N)) && (e.isJump || e.ctr >= 2);
  endfunction

  function automatic bit [31:0] modelTarget(bit [31:0] pc);
    return modelTaken(pc) ? model[idxOf(pc)].target : pc + 32'd4;
  endfunction

  function automatic void modelUpdate(bit [1:0] kind, bit [31:0] upc, bit ut, bit [31:0] utgt);
    int i;
    bit jump;
    bit [31:0] t;
    i = idxOf(upc);
    t = upc / (4 * N);
    jump = (kind == 2'd1) || (kind == 2'd2);
    if (model[i].v && model[i].tag == t) begin
      if (jump) begin
        model[i].ctr = 3;
        model[i].isJump = 1'b1;
        model[i].target = utgt;
      end else if (ut) begin
        model[i].ctr = (model[i].ctr == 3) ? 3 : model[i].ctr + 1;
        model[i].target = utgt;
      end else begin
        model[i].ctr = (model[i].ctr == 0) ? 0 : model[i].ctr - 1;
      end
    end else if (ut) begin
      model[i] = '{v: 1'b1, tag: t, target: utgt, ctr: jump ? 3 : 2, isJump: jump};
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected response per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("pc_o", pc_o, e.pc);
      checkOutput("pred_taken_o", {31'b0, pred_taken_o}, {31'b0, e.predTaken});
      checkOutput("pred_target_o", pred_target_o, e.predTarget);
      checkOutput("redirect_o", {31'b0, redirect_o}, {31'b0, e.redirect});
      checkOutput("redirect_pc_o", redirect_pc_o, e.redirectPc);
    end
  end

  // Called #1 after a rising edge; returns #1 after the following edge.
  task automatic applyStimulus(input bit stall, input bit uv, input bit [1:0] kind,
                               input bit [31:0] upc, input bit ut, input bit [31:0] utgt,
                               input bit upt, input bit [31:0] uptgt);
    exp_t e;
    bit mis;
    stall_i = stall;
    upd_valid_i = uv;
    upd_kind_i = kind;
    upd_pc_i = upc;
    upd_taken_i = ut;
    upd_target_i = utgt;
    upd_pred_taken_i = upt;
    upd_pred_target_i = uptgt;
    mis = uv && ((ut != upt) || (ut && utgt != uptgt));
    e.pc = modelPc;
    e.predTaken = modelTaken(modelPc);
    e.predTarget = modelTarget(modelPc);
    e.redirect = mis;
    e.redirectPc = mis ? (ut ? utgt : upc + 32'd4) : 32'h0;
    expQ.push_back(e);
    if (mis) modelPc = e.redirectPc;
    else if (!stall) modelPc = e.predTarget;
    if (uv) modelUpdate(kind, upc, ut, utgt);
    @(posedge clk);
    #1;
    stall_i = 1'b0;
    upd_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 2'd0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Steers fetch to pc by resolving a not-taken branch that was predicted taken.
  task automatic jumpTo(input bit [31:0] pc);
    applyStimulus(0, 1, UPD_BRANCH, pc - 32'd4, 0, 32'h0, 1, 32'h0);
  endtask

  task automatic applyReset();
    exp_t e;
    stall_i = 1'b0;
    upd_valid_i = 1'b0;
    rst = 1'b1;
    modelReset();
    e = '{pc: 32'h0, predTaken: 1'b0, predTarget: 32'h4, redirect: 1'b0, redirectPc: 32'h0};
    expQ.push_back(e);
    #1;
    checkOutput("rst_async_pc", pc_o, 32'h0);
    checkOutput("rst_async_pred", {31'b0, pred_taken_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit        st, uv, ut, upt;
    bit [1:0]  kind;
    bit [31:0] upc, utgt, uptgt;

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    idle(15);
    checkOutput("pre_reset_pc", pc_o, 32'h3C);
    applyReset();
    for (int k = 1; k <= 3; k++) begin
      idle(1);
      checkOutput("post_reset_pc", pc_o, 32'(4 * k));
    end

    idle(1);
    applyStimulus(1, 0, 2'd0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("stall_hold1", pc_o, 32'h10);
    applyStimulus(1, 0, 2'd0, 32'h0, 0, 32'h0, 0, 32'h0);
    checkOutput("stall_hold2", pc_o, 32'h10);
    idle(1);
    checkOutput("stall_release", pc_o, 32'h14);
    applyStimulus(1, 1, UPD_BRANCH, 32'h70, 1, 32'h80, 0, 32'h0);
    checkOutput("redirect_in_stall", pc_o, 32'h80);

    applyStimulus(0, 1, UPD_BRANCH, 32'h20, 1, 32'h40, 0, 32'h0);
    checkOutput("learn_redirect_pc", pc_o, 32'h40);
    jumpTo(32'h20);
    checkOutput("learn_pred_taken", {31'b0, pred_taken_o}, 32'h1);
    checkOutput("learn_pred_target", pred_target_o, 32'h40);

    applyStimulus(0, 1, UPD_BRANCH, 32'h20, 0, 32'h0, 1, 32'h40);
    checkOutput("hyst_nt_redirect", pc_o, 32'h24);
    jumpTo(32'h20);
    checkOutput("hyst_pred_nt", {31'b0, pred_taken_o}, 32'h0);
    applyStimulus(0, 1, UPD_BRANCH, 32'h20, 1, 32'h40, 0, 32'h0);
    applyStimulus(0, 1, UPD_BRANCH, 32'h20, 1, 32'h40, 1, 32'h40);
    applyStimulus(0, 1, UPD_BRANCH, 32'h20, 1, 32'h40, 1, 32'h40);
    applyStimulus(0, 1, UPD_BRANCH, 32'h20, 0, 32'h0, 1, 32'h40);
    jumpTo(32'h20);
    checkOutput("hyst_sat_pred", {31'b0, pred_taken_o}, 32'h1);

    applyStimulus(0, 1, UPD_JALR, 32'h50, 1, 32'h100, 0, 32'h0);
    applyStimulus(0, 1, UPD_JALR, 32'h50, 1, 32'h200, 1, 32'h100);
    checkOutput("jalr_redirect_pc", pc_o, 32'h200);
    jumpTo(32'h50);
    checkOutput("jalr_pred_taken", {31'b0, pred_taken_o}, 32'h1);
    checkOutput("jalr_pred_target", pred_target_o, 32'h200);

    jumpTo(32'h60);
    checkOutput("alias_pred", {31'b0, pred_taken_o}, 32'h0);
    jumpTo(32'hFFFF_FFFC);
    checkOutput("wrap_fetch_pc", pc_o, 32'hFFFF_FFFC);
    idle(1);
    checkOutput("wrap_pc", pc_o, 32'h0);
    applyStimulus(0, 1, UPD_BRANCH, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h8);
    checkOutput("wrap_redirect_pc", pc_o, 32'h0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        applyReset();
        continue;
      end
      st = ($urandom_range(0, 3) == 0);
      uv = $urandom_range(0, 1);
      kind = 2'($urandom_range(0, 3));
      upc = ($urandom_range(0, 3) == 0 ? 32'h1000 : 32'h0) + 32'($urandom_range(0, 31)) * 4;
      utgt = 32'($urandom_range(0, 63)) * 4;
      ut = ((kind == 2'd1) || (kind == 2'd2)) ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        upt = modelTaken(upc);
        uptgt = modelTarget(upc);
      end else begin
        upt = $urandom_range(0, 1);
        uptgt = 32'($urandom_range(0, 63)) * 4;
      end
      applyStimulus(st, uv, kind, upc, ut, utgt, upt, uptgt);
    end

    idle(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
